// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word width and pipeline stall controller states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_ctrl_state_t;

  localparam lc3b_word SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc,
  output lc3b_word count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != SAT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline register enable / bubble / flush control for the LC-3b 5-stage pipe.
// Optional performance counters are built only with PIPE_PERF_CNT_EN defined.
//
// state    | meaning
// RUN      | normal issue; load-use bubbles and branch flushes applied directly
// MEM_WAIT | pipeline frozen on a cache miss; taken branch remembered in flush_pend
module pipeline_stall_ctrl
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_use_hazard,
  input  logic     icache_read,
  input  logic     icache_resp,
  input  logic     dcache_req,
  input  logic     dcache_resp,
  input  logic     br_taken,
  output logic     pc_load,
  output logic     if_id_load,
  output logic     id_ex_load,
  output logic     ex_mem_load,
  output logic     mem_wb_load,
  output logic     id_ex_bubble,
  output logic     flush,
  output lc3b_word stall_cycles,
  output lc3b_word flush_count
);

  pipe_ctrl_state_t state;
  logic             flush_pend;
  logic             mem_stall;
  logic             flush_cond;
  logic             lu_stall;

  assign mem_stall  = (icache_read & ~icache_resp) | (dcache_req & ~dcache_resp);
  assign flush_cond = br_taken | flush_pend;
  // A hazard seen during a stall is not remembered; it is simply re-seen on release.
  assign lu_stall   = rst_n & ~mem_stall & ~flush_cond & load_use_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state      <= MEM_WAIT;
            flush_pend <= br_taken;
          end else begin
            flush_pend <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            flush_pend <= flush_pend | br_taken;
          end else begin
            state      <= RUN;
            flush_pend <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    id_ex_load   = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;
    if (rst_n && !mem_stall) begin
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
      if (flush_cond) begin
        pc_load    = 1'b1;
        if_id_load = 1'b1;
        flush      = 1'b1;
      end else if (lu_stall) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_load    = 1'b1;
        if_id_load = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;

  assign stall_inc = mem_stall | lu_stall;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed checks for pipeline_stall_ctrl; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipeline_stall_ctrl;
  import lc3b_types::*;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // output vector order: {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush}
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_ALL   = 7'b1111100;
  localparam logic [6:0] O_FLUSH = 7'b1111101;
  localparam logic [6:0] O_LU    = 7'b0011110;

  logic     clk, rst_n;
  logic     load_use_hazard, icache_read, icache_resp;
  logic     dcache_req, dcache_resp, br_taken;
  logic     pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic     id_ex_bubble, flush;
  lc3b_word stall_cycles, flush_count;
  logic [6:0] outs;

  int checks   = 0;
  int failures = 0;

  pipeline_stall_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_use_hazard (load_use_hazard),
    .icache_read     (icache_read),
    .icache_resp     (icache_resp),
    .dcache_req      (dcache_req),
    .dcache_resp     (dcache_resp),
    .br_taken        (br_taken),
    .pc_load         (pc_load),
    .if_id_load      (if_id_load),
    .id_ex_load      (id_ex_load),
    .ex_mem_load     (ex_mem_load),
    .mem_wb_load     (mem_wb_load),
    .id_ex_bubble    (id_ex_bubble),
    .flush           (flush),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  assign outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, id_ex_bubble, flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; load_use_hazard = 1'b0; icache_read = 1'b0; icache_resp = 1'b0;
    dcache_req = 1'b1; dcache_resp = 1'b0; br_taken = 1'b0;

    // reset held with a pending dcache miss
    #1;
    chk("rst_outs", {9'd0, outs}, {9'd0, O_NONE});
    chk("rst_stall_cnt", stall_cycles, 16'h0000);
    chk("rst_flush_cnt", flush_count, 16'h0000);
    next_cycle(); next_cycle();
    #1;
    chk("rst_outs_held", {9'd0, outs}, {9'd0, O_NONE});

    next_cycle();
    rst_n = 1'b1; dcache_req = 1'b0;
    #1;
    chk("rel_state", {15'd0, dut.state}, {15'd0, RUN});
    chk("rel_outs", {9'd0, outs}, {9'd0, O_ALL});
    @(posedge clk); #1;
    chk("first_edge_state", {15'd0, dut.state}, {15'd0, RUN});

    // 3-cycle dcache miss then response
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      dcache_req = 1'b1; dcache_resp = 1'b0;
      #1;
      chk($sformatf("miss3_stall%0d", i), {9'd0, outs}, {9'd0, O_NONE});
      next_cycle();
    end
    dcache_resp = 1'b1;
    #1;
    chk("miss3_release", {9'd0, outs}, {9'd0, O_ALL});
    next_cycle();
    dcache_req = 1'b0; dcache_resp = 1'b0;
    #1;
    chk("miss3_stall_cnt", stall_cycles, PERF ? 16'd3 : 16'd0);
    chk("miss3_state", {15'd0, dut.state}, {15'd0, RUN});

    // taken branch during the 2nd cycle of a 4-cycle miss
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      dcache_req = 1'b1; dcache_resp = 1'b0; br_taken = (i == 1);
      #1;
      chk($sformatf("br_stall%0d", i), {9'd0, outs}, {9'd0, O_NONE});
      next_cycle();
    end
    dcache_resp = 1'b1; br_taken = 1'b0;
    #1;
    chk("br_release_flush", {9'd0, outs}, {9'd0, O_FLUSH});
    next_cycle();
    dcache_req = 1'b0; dcache_resp = 1'b0;
    #1;
    chk("br_after", {9'd0, outs}, {9'd0, O_ALL});
    chk("br_flush_cnt", flush_count, PERF ? 16'd1 : 16'd0);
    chk("br_stall_cnt", stall_cycles, PERF ? 16'd7 : 16'd0);

    // single-cycle load-use hazard
    next_cycle();
    load_use_hazard = 1'b1;
    #1;
    chk("lu_bubble", {9'd0, outs}, {9'd0, O_LU});
    next_cycle();
    load_use_hazard = 1'b0;
    #1;
    chk("lu_after", {9'd0, outs}, {9'd0, O_ALL});
    chk("lu_stall_cnt", stall_cycles, PERF ? 16'd8 : 16'd0);

    // flush beats load-use
    next_cycle();
    load_use_hazard = 1'b1; br_taken = 1'b1;
    #1;
    chk("br_lu_prio", {9'd0, outs}, {9'd0, O_FLUSH});
    next_cycle();
    load_use_hazard = 1'b0; br_taken = 1'b0;
    #1;
    chk("br_lu_flush_cnt", flush_count, PERF ? 16'd2 : 16'd0);
    chk("br_lu_stall_cnt", stall_cycles, PERF ? 16'd8 : 16'd0);

    // long icache miss drives the stall counter to saturation
    next_cycle();
    icache_read = 1'b1; icache_resp = 1'b0;
    repeat (PERF ? 65526 : 4) next_cycle();
    #1;
    chk("sat_pre", stall_cycles, PERF ? 16'hFFFE : 16'd0);
    chk("sat_pre_outs", {9'd0, outs}, {9'd0, O_NONE});
    repeat (3) next_cycle();
    #1;
    chk("sat_hold", stall_cycles, PERF ? 16'hFFFF : 16'd0);
    chk("sat_flush_cnt", flush_count, PERF ? 16'd2 : 16'd0);
    icache_resp = 1'b1;
    #1;
    chk("sat_release", {9'd0, outs}, {9'd0, O_ALL});
    next_cycle();
    icache_read = 1'b0; icache_resp = 1'b0;

    // reset asserted in the middle of a stall
    dcache_req = 1'b1; dcache_resp = 1'b0;
    next_cycle(); next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {15'd0, dut.state}, {15'd0, RUN});
    chk("midrst_stall_cnt", stall_cycles, 16'h0000);
    chk("midrst_outs", {9'd0, outs}, {9'd0, O_NONE});
    next_cycle();
    rst_n = 1'b1; dcache_req = 1'b0;
    #1;
    chk("midrst_release", {9'd0, outs}, {9'd0, O_ALL});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_use_hazard  in  1  load-use hazard from hazard detection; 1 = dependent instruction in IF/ID.
- icache_read  in  1  fetch request active.
- icache_resp  in  1  fetch data valid this cycle.
- dcache_req  in  1  MEM-stage read or write active.
- dcache_resp  in  1  MEM-stage access complete this cycle.
- br_taken  in  1  taken branch/jump resolved in MEM.
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  pipeline register enables.
- id_ex_bubble  out  1  selects NOP control word into ID/EX.
- flush  out  1  clears IF/ID, ID/EX and EX/MEM to NOP on a loaded edge.
- stall_cycles, flush_count  out  16 each  performance counters (REQ-017).
REQ-002 Clocking SHALL be one clock (clk), with reset asynchronous and active-low (rst_n).

Function
REQ-003 mem_stall SHALL be the combinational signal (icache_read & ~icache_resp) | (dcache_req & ~dcache_resp).
REQ-004 The FSM SHALL have two states: RUN and MEM_WAIT. It SHALL also hold one register, flush_pend.
REQ-005 In any state, mem_stall=1 SHALL drive all five load enables to 0, with flush=0 and id_ex_bubble=0. The whole pipeline freezes.
REQ-006 RUN with mem_stall=1 SHALL go to MEM_WAIT at the next edge.
REQ-007 In MEM_WAIT, br_taken=1 SHALL set flush_pend at the next edge. While stalled, flush_pend SHALL stay set.
REQ-008 In MEM_WAIT, the first cycle with mem_stall=0 is the release cycle. In that cycle:
- all loads SHALL be 1;
- flush SHALL equal br_taken | flush_pend;
- the next state SHALL be RUN;
- flush_pend SHALL clear at the next edge.
REQ-009 RUN with mem_stall=0 and flush condition true SHALL:
- assert flush=1;
- set all loads to 1;
- force id_ex_bubble=0 (flush has priority over load-use).
REQ-010 RUN with mem_stall=0, no flush and load_use_hazard=1 SHALL set:
- pc_load=0 and if_id_load=0;
- id_ex_bubble=1;
- id_ex_load, ex_mem_load and mem_wb_load = 1.
This gives exactly one bubble per hazard cycle.
REQ-011 RUN with no stall, flush or hazard SHALL set all loads to 1, with flush=0 and id_ex_bubble=0.
REQ-012 A load-use hazard present during a memory stall SHALL NOT be latched. It is re-evaluated on the release cycle per REQ-008 to REQ-010, and flush suppresses it.
REQ-013 All outputs except the counters SHALL be combinational from state, flush_pend and inputs, with zero-cycle latency.

Reset
REQ-014 Asserting rst_n=0 at any time, including mid-stall, SHALL force state=RUN, flush_pend=0, stall_cycles=0 and flush_count=0 immediately.
REQ-015 While rst_n=0, all loads, flush and id_ex_bubble SHALL be 0.
REQ-016 After reset release, the first edge SHALL see state RUN.

Configuration
REQ-017 With the macro PIPE_PERF_CNT_EN defined:
- stall_cycles SHALL increment on each edge where mem_stall | load_use-stall is true;
- flush_count SHALL increment on each edge where flush=1;
- both counters SHALL saturate at 16'hFFFF and not wrap.
REQ-018 Without PIPE_PERF_CNT_EN, both counter outputs SHALL be constant 0 and no counter flops SHALL be instantiated.

Structure
REQ-019 The pipe_ctrl_state_t enum (RUN, MEM_WAIT) SHALL be added to lc3b_types. The counter width SHALL reuse lc3b_word.
REQ-020 One sub-module, sat_counter16, SHALL provide the saturating counter. It SHALL be instantiated twice, only under PIPE_PERF_CNT_EN.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Hold rst_n=0 with dcache_req=1: all outputs 0. Release reset: state RUN.
- Hold dcache_req=1 with dcache_resp=0 for 3 cycles, then resp=1: loads 0 for 3 cycles, then 1 for one cycle. stall_cycles=3 (macro on).
- Pulse br_taken=1 in the 2nd cycle of a 4-cycle dcache stall: no flush during the stall, flush=1 exactly on the release cycle, flush_count=1.
- Assert load_use_hazard=1 for one cycle in RUN: pc_load=if_id_load=0, id_ex_bubble=1, back-end loads 1. The next cycle is all loads 1.
- Assert br_taken=1 and load_use_hazard=1 in the same cycle: flush=1, id_ex_bubble=0, all loads 1.
- Preload stall_cycles to 16'hFFFE and hold a stall for 3 cycles: the counter holds at 16'hFFFF.
